// File: rtl/tanh_plan_arbiter.sv
// tanh_plan_arbiter: round-robin arbiter/sequencer sharing one PLAN tanh core
// among NUM_REQ requesters. One operation is outstanding at a time:
// grant -> launch -> wait for core -> hold response until accepted.
// Optional feature macro: TANH_ARB_TIMEOUT_EN (watchdog on the core wait,
// returns +1.0 with rsp_err=1 after TIMEOUT WAIT cycles).
module tanh_plan_arbiter #(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_x,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [N-1:0]         rsp_data,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [N-1:0]         core_x,
  input  logic                 core_done,
  input  logic [N-1:0]         core_result,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // +1.0 in Q(N/2).(N/2): the saturated tanh value used for watchdog errors
  localparam logic [N-1:0] SAT_ONE = N'(1) << (N/2);

  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     id;
  logic               found;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW-1:0]     rr_next;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               tmo;
  int                 idx;

  // Rotating priority search: walk offsets from the far end down so the
  // requester closest to rr_ptr (offset 0 first) wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Pointer moves one past the winner; explicit wrap keeps non-power-of-two
  // NUM_REQ correct.
  assign rr_next = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign gnt_oh  = NUM_REQ'(1) << gnt_idx;
  assign busy    = (state != S_IDLE);

`ifdef TANH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // Watchdog counter: cleared while issuing, counts each WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (state == S_ISSUE)  wait_cnt <= '0;
    else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the WAIT cycle in which the count reaches TIMEOUT
  assign tmo = (state == S_WAIT) && (wait_cnt == CW'(TIMEOUT - 1));

  // Error flag: a real core_done in the same cycle wins over the watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_q <= 1'b0;
    else if (state == S_WAIT)                err_q <= tmo && !core_done;
    else if (state == S_RESP && rsp_ready)   err_q <= 1'b0;
  end

  assign rsp_err = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Main sequencer: grant, launch, wait for the core, hold the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      id         <= '0;
      req_ready  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      core_start <= 1'b0;
      core_x     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            req_ready <= gnt_oh;
            core_x    <= req_x[gnt_idx*N +: N];
            id        <= gnt_idx;
            rr_ptr    <= rr_next;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          req_ready  <= '0;
          core_start <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          core_start <= 1'b0;
          if (core_done) begin
            rsp_data  <= core_result;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (tmo) begin
            rsp_data  <= SAT_ONE;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/tanh_plan_arbiter.md
Name: tanh_plan_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one PLAN tanh core among NUM_REQ requesters.
- Accepts fixed-point operands (Q(N/2).(N/2)) on per-requester valid/ready ports and launches one core evaluation at a time.
- Waits for core completion, then returns the result tagged with the requester index on a single valid/ready response port.
- Sits between the activation-request sources (e.g. LSTM gate lanes) and the single tanh datapath instance.

Parameters:
- N, 32, operand/result width, fixed point with N/2 fraction bits.
- NUM_REQ, 4, number of requesters (2..16).
- IDW, 2, requester-index width, clog2(NUM_REQ).
- TIMEOUT, 15, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_x  in  NUM_REQ*N  packed operands; requester i occupies bits [i*N +: N].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept from consumer.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  N  tanh result.
- rsp_err  out  1  result is a watchdog error (tied 0 without the optional feature).
- core_start  out  1  one-cycle launch pulse to the tanh core.
- core_x  out  N  operand to the core, held stable from launch until done.
- core_done  in  1  core result-valid pulse.
- core_result  in  N  core output, sampled when core_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; rr_ptr=0; req_ready=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; core_start=0; core_x=0; busy=0.
- Reset asserted mid-operation aborts the operation; the in-flight result is discarded and no response is issued.
- FSM, all outputs registered:
  - IDLE: find the first asserted req_valid searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ. If found at index g: req_ready[g]=1 for exactly one cycle (handshake completes that cycle), latch core_x=req_x[g] and id=g, set rr_ptr=(g+1) mod NUM_REQ, go to ISSUE. If none is found, stay in IDLE.
  - ISSUE: core_start=1 for one cycle; go to WAIT.
  - WAIT: hold core_x. On core_done=1, latch rsp_data=core_result, set rsp_id=id and rsp_valid=1, go to RESP. A core_done seen in IDLE or ISSUE is ignored.
  - RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
- No new grant is issued until the response is accepted, so at most one operation is outstanding.
- Minimum request-to-response latency: 3 cycles plus core latency. Back-to-back throughput: one operation per (core latency + 4) cycles with rsp_ready tied high.
- Fairness: a requester holding req_valid is granted within NUM_REQ operations. Simultaneous requests are granted in rotating order starting at rr_ptr.
- Requesters must hold req_x stable while req_valid=1 and not ready. Deasserting req_valid before grant is legal and drops the request silently.
- Arithmetic: data passes through unmodified. Only rr_ptr arithmetic is modulo NUM_REQ, including for non-power-of-two NUM_REQ.

Optional Feature:
- TANH_ARB_TIMEOUT_EN defined:
  - A wait counter clears on ISSUE and increments every WAIT cycle.
  - If it reaches TIMEOUT without core_done, go to RESP with rsp_data={N/2-1 zeros, 1, N/2 zeros} (+1.0 saturation), rsp_err=1, rsp_id=id.
  - rsp_err clears when the response is accepted.
  - A core_done arriving in the same cycle the counter reaches TIMEOUT takes priority: normal result, rsp_err=0.
- TANH_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; rsp_err tied 0.

Test Plan:
- Single request: req_valid=4'b0100, req_x[2]=0x00010000, core model returns 0x0000C2F7 after 7 cycles -> req_ready=4'b0100 for one cycle, one core_start pulse with core_x=0x00010000, then rsp_valid with rsp_id=2, rsp_data=0x0000C2F7.
- Contention: all four req_valid held high for 8 operations starting from reset -> grant order 0,1,2,3,0,1,2,3 and rsp_id in the same order.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid while req_valid[1]=1 -> rsp_data and rsp_id stay stable, req_ready stays 0 throughout, grant to requester 1 occurs only after acceptance.
- Reset mid-WAIT: assert rst_n=0 two cycles after core_start -> all outputs 0 asynchronously; after release, core_done is ignored and no rsp_valid is produced.
- Timeout (TANH_ARB_TIMEOUT_EN defined, TIMEOUT=15): core never asserts done -> 15 WAIT cycles later rsp_valid=1, rsp_err=1, rsp_data=0x00010000.
- Spurious done: core_done pulsed while in IDLE -> no state change and no rsp_valid.
